// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with done/req-drop release and hold-limit timeout
// One owner at a time; every release passes through one IDLE cycle before the next grant.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]  gnt_id_q, gnt_id_d;
  logic           timeout_q, timeout_d;
  logic [IW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           win_found;
  logic [IW-1:0]  win_id;
  logic [IW-1:0]  cand;
  logic           owner_req;
  logic           hold_hit;
  logic           release_grant;
  logic           forced;

  // Scan upward from last+1, wrapping so that last itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(last_q) + off) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    owner_req     = req[gnt_id_q];
    hold_hit      = (cnt_q == HOLD_MAX);
    release_grant = done | ~owner_req | hold_hit;
    // A hold-limit release only counts as a timeout if nothing else would have ended it.
    forced        = hold_hit & ~done & owner_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (win_found) begin
        state_d = GRANT;
      end
    end else begin
      if (release_grant) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (win_found) begin
        gnt_d       = ONE_HOT0 << win_id;
        gnt_valid_d = 1'b1;
        gnt_id_d    = win_id;
        last_d      = win_id;
      end else begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    end else begin
      if (release_grant) begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        cnt_d       = '0;
        timeout_d   = forced;
      end else if (!hold_hit) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_valid = gnt_valid_q;
    gnt_id    = gnt_id_q;
    timeout   = timeout_q;
    busy      = (state_q == GRANT);
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter (N=4, MAX_HOLD=15)
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;
  logic         busy;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout),
    .busy      (busy)
  );

  // One entry per expected grant: owner, cycles held, zero-gnt cycles before it (-1 = any),
  // and whether the release is a forced timeout.
  typedef struct {
    int id;
    int len;
    int gap;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int id, input int len, input int gap, input bit to);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.gap = gap;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_gnt_valid"}, int'(gnt_valid), 0);
    check({tag, "_gnt_id"}, int'(gnt_id), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  exp_t cur;
  bit   active = 1'b0;
  int   len_cnt = 0;
  int   gap_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_vs_valid", int'(busy), int'(gnt_valid));
      if (gnt_valid) begin
        if (!active) begin
          active  = 1'b1;
          len_cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_grant", int'(gnt_id), -1);
            cur.id  = int'(gnt_id);
            cur.len = -1;
            cur.gap = -1;
            cur.to  = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            check("grant_id", int'(gnt_id), cur.id);
            if (cur.gap >= 0) check("grant_gap", gap_cnt, cur.gap);
          end
        end
        len_cnt++;
        check("gnt_onehot", int'(gnt), 1 << gnt_id);
        check("owner_stable", int'(gnt_id), cur.id);
        check("timeout_in_grant", int'(timeout), 0);
      end else begin
        check("gnt_zero", int'(gnt), 0);
        check("gnt_id_zero", int'(gnt_id), 0);
        if (active) begin
          active  = 1'b0;
          gap_cnt = 0;
          if (cur.len >= 0) check("grant_len", len_cnt, cur.len);
          check("timeout_pulse", int'(timeout), int'(cur.to));
        end else begin
          check("timeout_idle", int'(timeout), 0);
        end
        gap_cnt++;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    tick(2);
    mon_en = 1'b1;
    check_all_zero("reset");

    // All requesting, done in the third cycle of each grant: 0,1,2,3,0.
    rst = 1'b0;
    req = 4'b1111;
    expect_grant(0, 3, -1, 1'b0);
    expect_grant(1, 3, 1, 1'b0);
    expect_grant(2, 3, 1, 1'b0);
    expect_grant(3, 3, 1, 1'b0);
    expect_grant(0, 3, 1, 1'b0);
    tick(1);
    check("first_gnt", int'(gnt), 1);
    check("first_gnt_id", int'(gnt_id), 0);
    check("first_busy", int'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      tick(2);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      if (k == 4) req = '0;
      tick(1);
    end

    // Lone requester 2 held: forced release after 16 cycles, then re-grant.
    req = 4'b0100;
    expect_grant(2, 16, -1, 1'b1);
    expect_grant(2, 5, 1, 1'b0);
    tick(18);
    tick(4);
    req = '0;
    tick(2);

    // Owner 1 drops its request while 3 waits; 3's request is ignored until then.
    req = 4'b0010;
    expect_grant(1, 3, -1, 1'b0);
    expect_grant(3, 1, 1, 1'b0);
    tick(1);
    req = 4'b1010;
    tick(2);
    req = 4'b1000;
    tick(2);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req  = '0;
    tick(2);

    // done coincides with the hold limit: ordinary release, no timeout.
    req = 4'b0001;
    expect_grant(0, 16, -1, 1'b0);
    tick(16);
    done = 1'b1;
    tick(1);
    check("done_at_limit_timeout", int'(timeout), 0);
    done = 1'b0;
    req  = '0;
    tick(2);

    // Reset in the middle of a grant to 2; priority pointer returns to 3.
    req = 4'b0100;
    expect_grant(2, 3, -1, 1'b0);
    expect_grant(0, 1, 1, 1'b0);
    tick(3);
    rst = 1'b1;
    req = 4'b1111;
    tick(1);
    check_all_zero("mid_grant_reset");
    rst = 1'b0;
    tick(1);
    check("post_reset_gnt", int'(gnt), 1);
    check("post_reset_gnt_id", int'(gnt_id), 0);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    req  = '0;
    tick(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
